ram_access_sequencer: RTL and testbench

// Upstream master of the 1536x8 block-RAM wrapper: turns one CPU load/store (byte, half, word)

---
 rtl/ram_access_sequencer.sv | 156 +++++++++++++++
 tb/tb_ram_access_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_access_sequencer.sv
// Purpose: turns one CPU load/store (byte/half/word, any alignment) into single-byte RAM accesses.
// Latency: load 2N cycles of RAM access then a response cycle; store N write cycles then a response cycle.
// Backpressure: req_ready is high only in IDLE; one request in flight, no queueing, no back-to-back accept.
//
// Ports:
//   CLK, reset          single clock (also the RAM's RCLK/WCLK), synchronous active-high reset
//   req_*               CPU request: valid/ready handshake, we, size, unsigned, byte address, store data
//   resp_valid/rdata    one-cycle completion pulse; rdata holds the load result (0 after a store)
//   ram_re/raddr/rdata  byte read port of the block-RAM wrapper
//   ram_we/waddr/wdata  byte write port of the block-RAM wrapper
module ram_access_sequencer #(
  parameter int ADDR_W = 11
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx_q;
  logic [31:0]       acc_q;
  logic [31:0]       rdata_q;

  logic [1:0]        last_idx;
  logic              is_last;
  logic [ADDR_W-1:0] byte_addr;
  logic [31:0]       merged;
  logic [31:0]       load_result;

  // Size 11 is handled like a word.
  assign last_idx  = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign is_last   = (idx_q == last_idx);
  // Natural modulo-2**ADDR_W wrap; out-of-range bytes are left to the RAM to ignore.
  assign byte_addr = addr_q + ADDR_W'(idx_q);

  // The final byte is still on ram_rdata when the response value is formed,
  // so merge it in combinationally rather than waiting an extra cycle.
  always_comb begin
    merged = acc_q;
    merged[{idx_q, 3'b000} +: 8] = ram_rdata;
    case (size_q)
      2'b00:   load_result = uns_q ? {24'h0, merged[7:0]}
                                   : {{24{merged[7]}}, merged[7:0]};
      2'b01:   load_result = uns_q ? {16'h0, merged[15:0]}
                                   : {{16{merged[15]}}, merged[15:0]};
      default: load_result = merged;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = '0;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_we ? WR : RD_ADDR;
      end
      RD_ADDR: begin
        ram_re    = 1'b1;
        ram_raddr = byte_addr;
        state_d   = RD_CAP;
      end
      // Address held for a second cycle: the wrapper's output mux follows the live RADDR.
      RD_CAP: begin
        ram_re    = 1'b1;
        ram_raddr = byte_addr;
        state_d   = is_last ? RESP : RD_ADDR;
      end
      WR: begin
        ram_we    = 1'b1;
        ram_waddr = byte_addr;
        ram_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        state_d   = is_last ? RESP : WR;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx_q   <= 2'd0;
          end
        end
        RD_CAP: begin
          acc_q <= merged;
          if (is_last) rdata_q <= load_result;
          else         idx_q   <= idx_q + 2'd1;
        end
        WR: begin
          if (is_last) rdata_q <= '0;
          else         idx_q   <= idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
module tb_ram_access_sequencer;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        ram_re;
  logic [10:0] ram_raddr;
  bit   [7:0]  ram_rdata;
  logic        ram_we;
  logic [10:0] ram_waddr;
  logic [7:0]  ram_wdata;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: expected responses, write beats {addr,data}, read addresses.
  logic [31:0] rsp_q[$];
  logic [18:0] wr_q[$];
  logic [10:0] rd_q[$];

  // 1536x8 RAM model with registered read; out-of-range reads give 0, writes are dropped.
  bit [7:0] mem [0:1535];

  always #5 CLK = ~CLK;

  ram_access_sequencer #(.ADDR_W(11)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  always @(posedge CLK) begin
    if (ram_re) ram_rdata <= (ram_raddr < 11'd1536) ? mem[ram_raddr] : 8'h00;
    if (ram_we && ram_waddr < 11'd1536) mem[ram_waddr] <= ram_wdata;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  bit          rd_phase = 1'b0;
  logic [10:0] rd_exp   = '0;
  logic [18:0] wr_e;

  always @(negedge CLK) begin
    if (resp_valid) begin
      if (rsp_q.size() == 0) check("resp_spurious", 32'(resp_valid), 32'd0);
      else                   check("resp_rdata", resp_rdata, rsp_q.pop_front());
    end
    if (ram_we) begin
      if (wr_q.size() == 0) check("wr_spurious", 32'(ram_we), 32'd0);
      else begin
        wr_e = wr_q.pop_front();
        check("wr_addr", 32'(ram_waddr), 32'(wr_e[18:8]));
        check("wr_data", 32'(ram_wdata), 32'(wr_e[7:0]));
      end
    end else begin
      check("wr_idle_zero", {13'h0, ram_waddr, ram_wdata}, 32'd0);
    end
    if (ram_re) begin
      if (!rd_phase) begin
        if (rd_q.size() == 0) check("rd_spurious", 32'(ram_re), 32'd0);
        else begin
          rd_exp = rd_q.pop_front();
          check("rd_addr", 32'(ram_raddr), 32'(rd_exp));
        end
      end else begin
        check("rd_hold", 32'(ram_raddr), 32'(rd_exp));
      end
      rd_phase = ~rd_phase;
    end else begin
      rd_phase = 1'b0;
      check("rd_idle_zero", 32'(ram_raddr), 32'd0);
    end
  end

  task automatic do_req(bit we, bit [1:0] size, bit uns, logic [10:0] addr,
                        logic [31:0] wdata, logic [31:0] exp_rd, int exp_lat);
    int n;
    int lat;
    logic [10:0] a;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      a = addr + 11'(i);
      if (we) wr_q.push_back({a, wdata[8*i +: 8]});
      else    rd_q.push_back(a);
    end
    rsp_q.push_back(we ? 32'h0 : exp_rd);
    @(posedge CLK); #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge CLK); #1;
    // Keep valid high with scrambled fields: must be ignored until back in IDLE.
    req_we = ~we; req_size = 2'($urandom); req_unsigned = ~uns;
    req_addr = 11'($urandom); req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!resp_valid && lat < 40);
    req_valid = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge CLK); #1;
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("rdata_hold", resp_rdata, we ? 32'h0 : exp_rd);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_ram_re_we", {30'h0, ram_re, ram_we}, 32'd0);
    check("rst_addrs", {10'h0, ram_raddr, ram_waddr}, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;

    do_req(1, 2'd2, 0, 11'h004, 32'h11223344, 32'h0,        5);
    do_req(0, 2'd2, 0, 11'h004, 32'h0,        32'h11223344, 9);
    do_req(1, 2'd0, 0, 11'h006, 32'h000000A5, 32'h0,        2);
    do_req(0, 2'd0, 0, 11'h006, 32'h0,        32'hFFFFFFA5, 3);
    do_req(0, 2'd0, 1, 11'h006, 32'h0,        32'h000000A5, 3);
    do_req(0, 2'd1, 0, 11'h005, 32'h0,        32'hFFFFA533, 5);
    do_req(0, 2'd1, 1, 11'h005, 32'h0,        32'h0000A533, 5);
    do_req(0, 2'd3, 1, 11'h004, 32'h0,        32'h11A53344, 9);
    do_req(1, 2'd2, 0, 11'h1FE, 32'hDEADBEEF, 32'h0,        5);
    do_req(0, 2'd2, 0, 11'h1FE, 32'h0,        32'hDEADBEEF, 9);
    do_req(1, 2'd1, 0, 11'h5FE, 32'h00001234, 32'h0,        3);
    do_req(0, 2'd2, 0, 11'h5FE, 32'h0,        32'h00001234, 9);
    do_req(1, 2'd1, 0, 11'h7FF, 32'h0000BEEF, 32'h0,        3);
    do_req(0, 2'd1, 0, 11'h7FF, 32'h0,        32'hFFFFBE00, 5);
    do_req(0, 2'd0, 0, 11'h000, 32'h0,        32'hFFFFFFBE, 3);

    // Reset during the second write cycle of a word store: bytes 0..1 only, no response.
    wr_q.push_back({11'h100, 8'hBE});
    wr_q.push_back({11'h101, 8'hBA});
    @(posedge CLK); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 11'h100; req_wdata = 32'hCAFEBABE;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_ram_we", 32'(ram_we), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    repeat (6) @(negedge CLK);

    do_req(0, 2'd2, 0, 11'h100, 32'h0, 32'h0000BABE, 9);

    repeat (3) @(posedge CLK);
    #1;
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    check("wr_q_empty",  32'(wr_q.size()),  32'd0);
    check("rd_q_empty",  32'(rd_q.size()),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
